// File: rtl/conv_window_indexer_if.sv
// Handshake and index bundle between the window indexer and its consumers.
// master = indexer side, slave = controller/datapath side.
`timescale 1ns/1ps
interface conv_window_indexer_if #(
    parameter int WIDTH_BIT = 8
);
    logic                 start;
    logic                 clear;
    logic                 ready;
    logic                 valid;
    logic [WIDTH_BIT-1:0] out_row;
    logic [WIDTH_BIT-1:0] out_col;
    logic [WIDTH_BIT-1:0] k_row;
    logic [WIDTH_BIT-1:0] k_col;
    logic [WIDTH_BIT-1:0] ch;
    logic [WIDTH_BIT-1:0] in_row;
    logic [WIDTH_BIT-1:0] in_col;
    logic                 win_first;
    logic                 win_last;
    logic                 frame_last;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, clear, ready,
        output valid, out_row, out_col, k_row, k_col, ch, in_row, in_col,
               win_first, win_last, frame_last, busy, done
    );

    modport slave (
        output start, clear, ready,
        input  valid, out_row, out_col, k_row, k_col, ch, in_row, in_col,
               win_first, win_last, frame_last, busy, done
    );
endinterface

// File: rtl/conv_window_indexer.sv
// Walks every output position / channel / kernel element of a 2-D convolution,
// emitting registered coordinates and window/frame flags on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start, all outputs 0
// RUN   | streaming beats, valid = busy = 1
// DONE  | one-cycle done pulse after the frame_last beat is accepted
`timescale 1ns/1ps
module conv_window_indexer #(
    parameter int IN_ROWS   = 5,
    parameter int IN_COLS   = 5,
    parameter int K_SIZE    = 3,
    parameter int STRIDE    = 1,
    parameter int CHANNELS  = 1,
    parameter int WIDTH_BIT = 8
) (
    input logic                  clock,
    input logic                  reset,
    conv_window_indexer_if.master bus
);

    localparam int OUT_ROWS = (IN_ROWS - K_SIZE) / STRIDE + 1;
    localparam int OUT_COLS = (IN_COLS - K_SIZE) / STRIDE + 1;

    localparam logic [WIDTH_BIT-1:0] K_LAST  = WIDTH_BIT'(K_SIZE - 1);
    localparam logic [WIDTH_BIT-1:0] CH_LAST = WIDTH_BIT'(CHANNELS - 1);
    localparam logic [WIDTH_BIT-1:0] OR_LAST = WIDTH_BIT'(OUT_ROWS - 1);
    localparam logic [WIDTH_BIT-1:0] OC_LAST = WIDTH_BIT'(OUT_COLS - 1);
    localparam logic [WIDTH_BIT-1:0] STEP    = WIDTH_BIT'(STRIDE);
    localparam logic [WIDTH_BIT-1:0] ONE     = WIDTH_BIT'(1);
    localparam logic [WIDTH_BIT-1:0] ZERO    = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic load;
    logic step;
    logic flush;

    logic [WIDTH_BIT-1:0] out_row_q, out_col_q, ch_q, k_row_q, k_col_q;
    logic [WIDTH_BIT-1:0] out_row_n, out_col_n, ch_n, k_row_n, k_col_n;
    logic [WIDTH_BIT-1:0] row_base_q, col_base_q;
    logic [WIDTH_BIT-1:0] row_base_n, col_base_n;
    logic [WIDTH_BIT-1:0] in_row_q, in_col_q;
    logic [WIDTH_BIT-1:0] in_row_n, in_col_n;
    logic                 win_first_q, win_last_q, frame_last_q;
    logic                 win_first_n, win_last_n, frame_last_n;

    logic accept;
    logic kc_wrap, kr_wrap, ch_wrap, oc_wrap, or_wrap;
    logic frame_end;
    logic run_n;

    assign accept    = (state == RUN) && bus.ready;
    assign kc_wrap   = (k_col_q   == K_LAST);
    assign kr_wrap   = (k_row_q   == K_LAST);
    assign ch_wrap   = (ch_q      == CH_LAST);
    assign oc_wrap   = (out_col_q == OC_LAST);
    assign or_wrap   = (out_row_q == OR_LAST);
    assign frame_end = kc_wrap && kr_wrap && ch_wrap && oc_wrap && or_wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // clear overrides every other transition and never produces a done pulse
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (frame_end) begin
                        state_next = DONE;
                        flush      = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                flush      = 1'b1;
            end
        endcase
        if (bus.clear) begin
            state_next = IDLE;
            load       = 1'b0;
            step       = 1'b0;
            flush      = 1'b1;
        end
    end

    // Nested counters; row/col bases track out_*·STRIDE by accumulation so the
    // input coordinate is a single add ahead of the output register.
    always_comb begin
        out_row_n  = out_row_q;
        out_col_n  = out_col_q;
        ch_n       = ch_q;
        k_row_n    = k_row_q;
        k_col_n    = k_col_q;
        row_base_n = row_base_q;
        col_base_n = col_base_q;
        if (load || flush) begin
            out_row_n  = ZERO;
            out_col_n  = ZERO;
            ch_n       = ZERO;
            k_row_n    = ZERO;
            k_col_n    = ZERO;
            row_base_n = ZERO;
            col_base_n = ZERO;
        end else if (step) begin
            k_col_n = k_col_q + ONE;
            if (kc_wrap) begin
                k_col_n = ZERO;
                k_row_n = k_row_q + ONE;
                if (kr_wrap) begin
                    k_row_n = ZERO;
                    ch_n    = ch_q + ONE;
                    if (ch_wrap) begin
                        ch_n       = ZERO;
                        out_col_n  = out_col_q + ONE;
                        col_base_n = col_base_q + STEP;
                        if (oc_wrap) begin
                            out_col_n  = ZERO;
                            col_base_n = ZERO;
                            out_row_n  = out_row_q + ONE;
                            row_base_n = row_base_q + STEP;
                            if (or_wrap) begin
                                out_row_n  = ZERO;
                                row_base_n = ZERO;
                            end
                        end
                    end
                end
            end
        end
    end

    assign run_n    = (state_next == RUN);
    assign in_row_n = row_base_n + k_row_n;
    assign in_col_n = col_base_n + k_col_n;

    always_comb begin
        win_first_n  = 1'b0;
        win_last_n   = 1'b0;
        frame_last_n = 1'b0;
        if (run_n) begin
            win_first_n  = (ch_n == ZERO) && (k_row_n == ZERO) && (k_col_n == ZERO);
            win_last_n   = (ch_n == CH_LAST) && (k_row_n == K_LAST) && (k_col_n == K_LAST);
            frame_last_n = win_last_n && (out_row_n == OR_LAST) && (out_col_n == OC_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_row_q    <= ZERO;
            out_col_q    <= ZERO;
            ch_q         <= ZERO;
            k_row_q      <= ZERO;
            k_col_q      <= ZERO;
            row_base_q   <= ZERO;
            col_base_q   <= ZERO;
            in_row_q     <= ZERO;
            in_col_q     <= ZERO;
            win_first_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            out_row_q    <= out_row_n;
            out_col_q    <= out_col_n;
            ch_q         <= ch_n;
            k_row_q      <= k_row_n;
            k_col_q      <= k_col_n;
            row_base_q   <= row_base_n;
            col_base_q   <= col_base_n;
            in_row_q     <= in_row_n;
            in_col_q     <= in_col_n;
            win_first_q  <= win_first_n;
            win_last_q   <= win_last_n;
            frame_last_q <= frame_last_n;
        end
    end

    assign bus.valid      = (state == RUN);
    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.ch         = ch_q;
    assign bus.k_row      = k_row_q;
    assign bus.k_col      = k_col_q;
    assign bus.in_row     = in_row_q;
    assign bus.in_col     = in_col_q;
    assign bus.win_first  = win_first_q;
    assign bus.win_last   = win_last_q;
    assign bus.frame_last = frame_last_q;

endmodule

// File: tb/tb_conv_window_indexer.sv
// Bench for conv_window_indexer: three configurations (basic, stride 2, two channels)
// checked beat-by-beat against an index-decomposition model plus a hand-computed table.
`timescale 1ns/1ps
module tb_conv_window_indexer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       valid;
        logic       busy;
        logic       done;
        logic       wf;
        logic       wl;
        logic       fl;
        logic [7:0] orow;
        logic [7:0] ocol;
        logic [7:0] chn;
        logic [7:0] kr;
        logic [7:0] kc;
        logic [7:0] ir;
        logic [7:0] ic;
    } obs_t;

    typedef struct {
        int cfg;
        int beat;
        int orow, ocol, chn, kr, kc, ir, ic;
        bit wf, wl, fl;
    } vec_t;

    logic [2:0] start_v = '0;
    logic [2:0] clear_v = '0;
    logic [2:0] ready_v = '0;

    obs_t obs [3];
    obs_t cap [3][100];

    int checks = 0;
    int passes = 0;

    conv_window_indexer_if #(.WIDTH_BIT(8)) b0 ();
    conv_window_indexer_if #(.WIDTH_BIT(8)) b1 ();
    conv_window_indexer_if #(.WIDTH_BIT(8)) b2 ();

    assign b0.start = start_v[0];
    assign b0.clear = clear_v[0];
    assign b0.ready = ready_v[0];
    assign b1.start = start_v[1];
    assign b1.clear = clear_v[1];
    assign b1.ready = ready_v[1];
    assign b2.start = start_v[2];
    assign b2.clear = clear_v[2];
    assign b2.ready = ready_v[2];

    assign obs[0] = {b0.valid, b0.busy, b0.done, b0.win_first, b0.win_last, b0.frame_last,
                     b0.out_row, b0.out_col, b0.ch, b0.k_row, b0.k_col, b0.in_row, b0.in_col};
    assign obs[1] = {b1.valid, b1.busy, b1.done, b1.win_first, b1.win_last, b1.frame_last,
                     b1.out_row, b1.out_col, b1.ch, b1.k_row, b1.k_col, b1.in_row, b1.in_col};
    assign obs[2] = {b2.valid, b2.busy, b2.done, b2.win_first, b2.win_last, b2.frame_last,
                     b2.out_row, b2.out_col, b2.ch, b2.k_row, b2.k_col, b2.in_row, b2.in_col};

    conv_window_indexer #(.IN_ROWS(5), .IN_COLS(5), .K_SIZE(3), .STRIDE(1), .CHANNELS(1), .WIDTH_BIT(8))
        u_basic (.clock(clock), .reset(reset), .bus(b0));
    conv_window_indexer #(.IN_ROWS(5), .IN_COLS(5), .K_SIZE(3), .STRIDE(2), .CHANNELS(1), .WIDTH_BIT(8))
        u_stride (.clock(clock), .reset(reset), .bus(b1));
    conv_window_indexer #(.IN_ROWS(3), .IN_COLS(3), .K_SIZE(2), .STRIDE(1), .CHANNELS(2), .WIDTH_BIT(8))
        u_chan (.clock(clock), .reset(reset), .bus(b2));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    function automatic int cfg_k(input int c);
        return (c == 2) ? 2 : 3;
    endfunction
    function automatic int cfg_s(input int c);
        return (c == 1) ? 2 : 1;
    endfunction
    function automatic int cfg_ch(input int c);
        return (c == 2) ? 2 : 1;
    endfunction
    function automatic int cfg_in(input int c);
        return (c == 2) ? 3 : 5;
    endfunction
    function automatic int cfg_out(input int c);
        return (cfg_in(c) - cfg_k(c)) / cfg_s(c) + 1;
    endfunction
    function automatic int cfg_beats(input int c);
        return cfg_out(c) * cfg_out(c) * cfg_ch(c) * cfg_k(c) * cfg_k(c);
    endfunction

    // Decompose the beat index in loop order out_row, out_col, ch, k_row, k_col.
    function automatic obs_t exp_beat(input int c, input int n);
        obs_t e;
        int k, s, nch, oc, t, kc, kr, cv, ocv, orv;
        k   = cfg_k(c);
        s   = cfg_s(c);
        nch = cfg_ch(c);
        oc  = cfg_out(c);
        kc  = n % k;  t = n / k;
        kr  = t % k;  t = t / k;
        cv  = t % nch; t = t / nch;
        ocv = t % oc;
        orv = t / oc;
        e = '0;
        e.valid = 1'b1;
        e.busy  = 1'b1;
        e.orow  = 8'(orv);
        e.ocol  = 8'(ocv);
        e.chn   = 8'(cv);
        e.kr    = 8'(kr);
        e.kc    = 8'(kc);
        e.ir    = 8'(orv * s + kr);
        e.ic    = 8'(ocv * s + kc);
        e.wf    = (cv == 0) && (kr == 0) && (kc == 0);
        e.wl    = (cv == nch - 1) && (kr == k - 1) && (kc == k - 1);
        e.fl    = (n == cfg_beats(c) - 1);
        return e;
    endfunction

    function automatic obs_t vec_obs(input vec_t v);
        obs_t e;
        e = '0;
        e.valid = 1'b1;
        e.busy  = 1'b1;
        e.orow  = 8'(v.orow);
        e.ocol  = 8'(v.ocol);
        e.chn   = 8'(v.chn);
        e.kr    = 8'(v.kr);
        e.kc    = 8'(v.kc);
        e.ir    = 8'(v.ir);
        e.ic    = 8'(v.ic);
        e.wf    = v.wf;
        e.wl    = v.wl;
        e.fl    = v.fl;
        return e;
    endfunction

    // Runs one frame on DUT c. Optional stall (ready low stall_len cycles at beat
    // stall_at), a start pulse at beat ign_at, and a start pulse during DONE.
    task automatic drive_frame(input int c, input int stall_at, input int stall_len,
                               input int ign_at, input bit ign_done,
                               output int vcount, output int dcycle);
        int  n;
        int  stalls;
        int  cyc;
        bit  finished;
        n = 0; stalls = 0; finished = 1'b0;
        vcount = 0; dcycle = -1;
        ready_v[c] = 1'b1;
        start_v[c] = 1'b1;
        tick();
        start_v[c] = 1'b0;
        cyc = 1;
        while (!finished && cyc < 400) begin
            if (obs[c].valid) begin
                vcount++;
                chk($sformatf("beat cfg%0d n%0d", c, n), obs[c], exp_beat(c, n));
                if (n < 100) cap[c][n] = obs[c];
                start_v[c] = (n == ign_at);
                if (n == stall_at && stalls < stall_len) begin
                    ready_v[c] = 1'b0;
                    stalls++;
                end else begin
                    ready_v[c] = 1'b1;
                    n++;
                end
            end else if (obs[c].done) begin
                dcycle     = cyc;
                finished   = 1'b1;
                start_v[c] = ign_done;
            end else begin
                chk($sformatf("gap cfg%0d n%0d", c, n), obs[c], exp_beat(c, n));
                finished = 1'b1;
            end
            tick();
            cyc++;
        end
        start_v[c] = 1'b0;
        ready_v[c] = 1'b1;
        if (!finished) begin
            checks++;
            $display("FAIL timeout cfg%0d: got no done within 400 cycles, want done", c);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("idle cfg%0d +%0d", c, i), obs[c], '0);
            tick();
        end
    endtask

    vec_t tbl [14];

    initial begin
        int vc;
        int dc;
        int cnt;

        tbl[0]  = '{0,  0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{0,  8, 0, 0, 0, 2, 2, 2, 2, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{0,  9, 0, 1, 0, 0, 0, 0, 1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{0, 27, 1, 0, 0, 0, 0, 1, 0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{0, 40, 1, 1, 0, 1, 1, 2, 2, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{0, 80, 2, 2, 0, 2, 2, 4, 4, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1,  9, 0, 1, 0, 0, 0, 0, 2, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1, 22, 1, 0, 0, 1, 1, 3, 1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1, 35, 1, 1, 0, 2, 2, 4, 4, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{2,  3, 0, 0, 0, 1, 1, 1, 1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2,  4, 0, 0, 1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2,  7, 0, 0, 1, 1, 1, 1, 1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{2,  8, 0, 1, 0, 0, 0, 0, 1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{2, 31, 1, 1, 1, 1, 1, 2, 2, 1'b0, 1'b1, 1'b1};

        repeat (3) tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) chk($sformatf("reset cfg%0d", c), obs[c], '0);
        tick();

        drive_frame(0, -1, 0, -1, 1'b0, vc, dc);
        chk_int("basic valid beats", vc, 81);
        chk_int("basic done cycle", dc, 82);

        drive_frame(1, -1, 0, -1, 1'b0, vc, dc);
        chk_int("stride valid beats", vc, 36);
        chk_int("stride done cycle", dc, 37);
        cnt = 0;
        for (int i = 0; i < 36; i++) if (cap[1][i].ocol == 8'd2) cnt++;
        chk_int("stride out_col=2 beats", cnt, 0);

        drive_frame(2, -1, 0, -1, 1'b0, vc, dc);
        chk_int("chan valid beats", vc, 32);
        chk_int("chan done cycle", dc, 33);
        cnt = 0;
        for (int i = 0; i < 8; i++) if (cap[2][i].wl) cnt++;
        chk_int("chan win_last in first window", cnt, 1);

        for (int i = 0; i < 14; i++)
            chk($sformatf("table cfg%0d beat%0d", tbl[i].cfg, tbl[i].beat),
                cap[tbl[i].cfg][tbl[i].beat], vec_obs(tbl[i]));

        drive_frame(0, 10, 3, -1, 1'b0, vc, dc);
        chk_int("backpressure valid cycles", vc, 84);
        chk_int("backpressure done cycle", dc, 85);

        drive_frame(0, -1, 0, 30, 1'b1, vc, dc);
        chk_int("ignored start valid beats", vc, 81);
        chk_int("ignored start done cycle", dc, 82);

        // clear at beat 20, then restart
        ready_v[0] = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (20) tick();
        chk("abort pre", obs[0], exp_beat(0, 20));
        clear_v[0] = 1'b1;
        tick();
        clear_v[0] = 1'b0;
        chk("abort idle", obs[0], '0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("abort no done +%0d", i), obs[0], '0);
        end
        clear_v[0] = 1'b1;
        start_v[0] = 1'b1;
        tick();
        clear_v[0] = 1'b0;
        start_v[0] = 1'b0;
        chk("clear beats start", obs[0], '0);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        chk("restart beat0", obs[0], exp_beat(0, 0));
        repeat (5) tick();
        chk("restart beat5", obs[0], exp_beat(0, 5));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset mid-frame", obs[0], '0);
        tick();
        chk("reset mid-frame hold", obs[0], '0);

        drive_frame(0, -1, 0, -1, 1'b0, vc, dc);
        chk_int("post-reset valid beats", vc, 81);
        chk_int("post-reset done cycle", dc, 82);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
